// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared Q16.16 ray/triangle types, sweep states and wide-math helpers
package rt_pkg;

    typedef logic signed [31:0] fixed_t;
    typedef fixed_t [0:2]       vec3_t;
    typedef vec3_t  [0:1]       ray_t;
    typedef vec3_t  [0:2]       triangle_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EVAL,
        S_DONE
    } sweep_state_e;

    // Wide enough that the scaled intersection terms never wrap:
    // a dot of 33-bit differences with 67-bit cross terms, shifted by 16
    // or multiplied by a 32-bit threshold, stays well below 160 bits.
    localparam int WIDE_W = 160;
    typedef logic signed [WIDE_W-1:0] wide_t;
    typedef wide_t [0:2]              wvec_t;

    function automatic wide_t widen(input fixed_t x);
        return {{(WIDE_W-32){x[31]}}, x};
    endfunction

    function automatic wvec_t wext(input vec3_t a);
        wvec_t r;
        for (int i = 0; i < 3; i++) r[i] = widen(a[i]);
        return r;
    endfunction

    function automatic wvec_t wsub(input vec3_t a, input vec3_t b);
        wvec_t r;
        for (int i = 0; i < 3; i++) r[i] = widen(a[i]) - widen(b[i]);
        return r;
    endfunction

    function automatic wvec_t wcross(input wvec_t a, input wvec_t b);
        wvec_t r;
        r[0] = a[1] * b[2] - a[2] * b[1];
        r[1] = a[2] * b[0] - a[0] * b[2];
        r[2] = a[0] * b[1] - a[1] * b[0];
        return r;
    endfunction

    function automatic wide_t wdot(input wvec_t a, input wvec_t b);
        return a[0] * b[0] + a[1] * b[1] + a[2] * b[2];
    endfunction

endpackage

// File: rtl/intersection.sv
// rtl/intersection.sv - combinational ray/triangle hit test (division-free Moller-Trumbore)
// Ports: min_t (param) nearest accepted distance; i_ray origin/direction;
//        i_tri vertices; o_result hit; o_invalid ray parallel to plane;
//        o_normal unnormalised (v1-v0)x(v2-v0) in Q16.16.
module intersection
    import rt_pkg::*;
#(
    parameter fixed_t min_t = '0
) (
    input  ray_t      i_ray,
    input  triangle_t i_tri,
    output logic      o_result,
    output logic      o_invalid,
    output vec3_t     o_normal
);

    wvec_t e1, e2, dir, tvec, pvec, qvec, nrm;
    wide_t det, u, v, t;
    wide_t det_a, u_a, v_a, t_a;

    always_comb begin
        e1   = wsub(i_tri[1], i_tri[0]);
        e2   = wsub(i_tri[2], i_tri[0]);
        dir  = wext(i_ray[1]);
        tvec = wsub(i_ray[0], i_tri[0]);
        pvec = wcross(dir, e2);
        qvec = wcross(tvec, e1);
        nrm  = wcross(e1, e2);
        det  = wdot(e1, pvec);
        u    = wdot(tvec, pvec);
        v    = wdot(dir, qvec);
        t    = wdot(e2, qvec);

        // Barycentrics and t are kept scaled by det; folding the sign of
        // det into all four lets every test be a plain comparison.
        det_a = det;
        u_a   = u;
        v_a   = v;
        t_a   = t;
        if (det < 0) begin
            det_a = -det;
            u_a   = -u;
            v_a   = -v;
            t_a   = -t;
        end

        o_invalid = (det == 0);
        // t_a carries the 2^48 scale of det; min_t is Q16.16, hence the shift.
        o_result  = !o_invalid && (u_a >= 0) && (v_a >= 0) &&
                    ((u_a + v_a) <= det_a) &&
                    ((t_a <<< 16) >= (widen(min_t) * det_a));

        for (int i = 0; i < 3; i++) o_normal[i] = fixed_t'(nrm[i] >>> 16);
    end

endmodule

// File: rtl/tri_sweep_ctrl.sv
// rtl/tri_sweep_ctrl.sv - any-hit sweep of triangles 0..N-1 through a 1-cycle-latency memory
// Ports: i_clk/i_rstn clock and sync active-low reset; i_ray_valid/o_ray_ready
//        ray request with i_ray and i_num_tris; o_mem_rd/o_mem_addr/i_mem_data
//        triangle memory; o_hit_valid/i_hit_ready result handshake with o_hit,
//        o_hit_idx, o_normal and o_invalid_cnt.
module tri_sweep_ctrl
    import rt_pkg::*;
#(
    parameter fixed_t MIN_T     = '0,
    parameter int     TRI_IDX_W = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_ray_valid,
    output logic                 o_ray_ready,
    input  ray_t                 i_ray,
    input  logic [TRI_IDX_W:0]   i_num_tris,
    output logic                 o_mem_rd,
    output logic [TRI_IDX_W-1:0] o_mem_addr,
    input  triangle_t            i_mem_data,
    output logic                 o_hit_valid,
    input  logic                 i_hit_ready,
    output logic                 o_hit,
    output logic [TRI_IDX_W-1:0] o_hit_idx,
    output vec3_t                o_normal,
    output logic [TRI_IDX_W:0]   o_invalid_cnt
);

    sweep_state_e         state_q, state_d;
    ray_t                 ray_q, ray_d;
    triangle_t            tri_q, tri_d;
    logic [TRI_IDX_W:0]   num_q, num_d;
    logic [TRI_IDX_W-1:0] idx_q, idx_d;
    logic [TRI_IDX_W:0]   inv_q, inv_d;
    logic                 hit_q, hit_d;
    logic [TRI_IDX_W-1:0] hit_idx_q, hit_idx_d;
    vec3_t                normal_q, normal_d;
    logic                 ready_q, mem_rd_q, hit_valid_q;

    logic                 x_result, x_invalid;
    vec3_t                x_normal;

    intersection #(.min_t(MIN_T)) u_intersection (
        .i_ray     (ray_q),
        .i_tri     (tri_q),
        .o_result  (x_result),
        .o_invalid (x_invalid),
        .o_normal  (x_normal)
    );

    always_comb begin
        state_d   = state_q;
        ray_d     = ray_q;
        tri_d     = tri_q;
        num_d     = num_q;
        idx_d     = idx_q;
        inv_d     = inv_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        normal_d  = normal_q;

        case (state_q)
            S_IDLE: begin
                if (i_ray_valid) begin
                    ray_d     = i_ray;
                    num_d     = i_num_tris;
                    idx_d     = '0;
                    inv_d     = '0;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    normal_d  = '0;
                    state_d   = (i_num_tris == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                tri_d   = i_mem_data;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (x_invalid && (inv_q != '1)) inv_d = inv_q + 1'b1;
                if (!x_invalid && x_result) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                    normal_d  = x_normal;
                    state_d   = S_DONE;
                end else if ({1'b0, idx_q} == (num_q - 1'b1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                // Back to IDLE only; the earliest new accept is the cycle after.
                if (i_hit_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            ray_q       <= '0;
            tri_q       <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            inv_q       <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            normal_q    <= '0;
            ready_q     <= 1'b1;
            mem_rd_q    <= 1'b0;
            hit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ray_q       <= ray_d;
            tri_q       <= tri_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            inv_q       <= inv_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            normal_q    <= normal_d;
            ready_q     <= (state_d == S_IDLE);
            mem_rd_q    <= (state_d == S_FETCH);
            hit_valid_q <= (state_d == S_DONE);
        end
    end

    assign o_ray_ready   = ready_q;
    assign o_mem_rd      = mem_rd_q;
    assign o_mem_addr    = idx_q;
    assign o_hit_valid   = hit_valid_q;
    assign o_hit         = hit_q;
    assign o_hit_idx     = hit_idx_q;
    assign o_normal      = normal_q;
    assign o_invalid_cnt = inv_q;

endmodule

// File: tb/tb_tri_sweep_ctrl.sv
// tb/tb_tri_sweep_ctrl.sv - scoreboard bench for tri_sweep_ctrl with directed ray/triangle vectors
module tb_tri_sweep_ctrl;
    import rt_pkg::*;

    localparam int IW = 12;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ray_valid;
    logic          ray_ready;
    ray_t          ray;
    logic [IW:0]   num_tris;
    logic          mem_rd;
    logic [IW-1:0] mem_addr;
    triangle_t     mem_data;
    logic          hit_valid;
    logic          hit_ready;
    logic          hit;
    logic [IW-1:0] hit_idx;
    vec3_t         normal;
    logic [IW:0]   invalid_cnt;

    always #5 clk = ~clk;

    tri_sweep_ctrl #(.MIN_T(32'sd0), .TRI_IDX_W(IW)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_ray_valid   (ray_valid),
        .o_ray_ready   (ray_ready),
        .i_ray         (ray),
        .i_num_tris    (num_tris),
        .o_mem_rd      (mem_rd),
        .o_mem_addr    (mem_addr),
        .i_mem_data    (mem_data),
        .o_hit_valid   (hit_valid),
        .i_hit_ready   (hit_ready),
        .o_hit         (hit),
        .o_hit_idx     (hit_idx),
        .o_normal      (normal),
        .o_invalid_cnt (invalid_cnt)
    );

    typedef struct {
        int    id;
        logic  h;
        int    idx;
        vec3_t nrm;
        int    inv;
        int    lat;
        int    reads;
    } exp_t;

    exp_t      sb[$];
    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        acc_edge = 0;
    int        rd_total = 0;
    int        rd_base = 0;
    logic      prev_valid = 1'b0;
    triangle_t mem[16];
    triangle_t junk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory, one cycle read latency; junk when not reading.
    always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr[3:0]] : junk;

    function automatic vec3_t vraw(input int x, input int y, input int z);
        vec3_t r;
        r[0] = fixed_t'(x);
        r[1] = fixed_t'(y);
        r[2] = fixed_t'(z);
        return r;
    endfunction

    function automatic vec3_t v3(input int x, input int y, input int z);
        return vraw(x * 65536, y * 65536, z * 65536);
    endfunction

    function automatic triangle_t tr(input vec3_t a, input vec3_t b, input vec3_t c);
        triangle_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        return r;
    endfunction

    // Triangle in plane z=c covering the z axis; normal (0,0,9).
    function automatic triangle_t tz(input int c);
        return tr(v3(-1, -1, c), v3(2, -1, c), v3(-1, 2, c));
    endfunction

    function automatic exp_t mk(input int id, input logic h, input int idx, input vec3_t n,
                                input int inv, input int lat, input int reads);
        exp_t e;
        e.id = id; e.h = h; e.idx = idx; e.nrm = n; e.inv = inv; e.lat = lat; e.reads = reads;
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic mon_step();
        exp_t e;
        if (mem_rd) begin
            check("rd_addr", 128'(mem_addr), 128'(rd_total - rd_base));
            rd_total++;
        end
        if (hit_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=hit_valid required=no_result");
            end else begin
                e = sb.pop_front();
                check($sformatf("r%0d_hit", e.id), 128'(hit), 128'(e.h));
                check($sformatf("r%0d_hit_idx", e.id), 128'(hit_idx), 128'(e.idx));
                check($sformatf("r%0d_normal", e.id), 128'(normal), 128'(e.nrm));
                check($sformatf("r%0d_invalid_cnt", e.id), 128'(invalid_cnt), 128'(e.inv));
                check($sformatf("r%0d_latency", e.id), 128'(cyc - acc_edge + 1), 128'(e.lat));
                check($sformatf("r%0d_reads", e.id), 128'(rd_total - rd_base), 128'(e.reads));
            end
        end
        prev_valid = hit_valid;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ray_ready"}, 128'(ray_ready), 128'(1));
        check({tag, "_mem_rd"}, 128'(mem_rd), 128'(0));
        check({tag, "_mem_addr"}, 128'(mem_addr), 128'(0));
        check({tag, "_hit_valid"}, 128'(hit_valid), 128'(0));
        check({tag, "_hit"}, 128'(hit), 128'(0));
        check({tag, "_hit_idx"}, 128'(hit_idx), 128'(0));
        check({tag, "_normal"}, 128'(normal), 128'(0));
        check({tag, "_invalid_cnt"}, 128'(invalid_cnt), 128'(0));
    endtask

    // Call at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic send(input ray_t r, input int n, input exp_t e);
        ray_t garbage;
        garbage[0] = v3(3, 3, 3);
        garbage[1] = v3(1, 0, 0);
        check($sformatf("r%0d_ready_before", e.id), 128'(ray_ready), 128'(1));
        sb.push_back(e);
        rd_base   = rd_total;
        acc_edge  = cyc + 1;
        ray       = r;
        num_tris  = (IW+1)'(n);
        ray_valid = 1'b1;
        @(negedge clk);
        ray_valid = 1'b0;
        ray       = garbage;
        num_tris  = (IW+1)'(3);
    endtask

    task automatic wait_result(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (hit_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_hit_valid required=hit_valid", name);
        end
    endtask

    initial begin
        ray_t  ray_z, ray_basic, ray_b;
        vec3_t n9, n_basic;
        triangle_t lat_tri, par_tri, basic_tri;

        ray_z[0]     = v3(0, 0, 0);
        ray_z[1]     = v3(0, 0, 1);
        ray_basic[0] = v3(0, 1, 1);
        ray_basic[1] = vraw(32'h30000, 32'h1000, 32'h11000);
        ray_b        = ray_z;
        n9           = v3(0, 0, 9);
        n_basic      = vraw(32'h40000, -131072, 0);
        basic_tri    = tr(v3(1, 1, 1), v3(2, 3, 2), v3(1, 1, 3));
        lat_tri      = tr(v3(5, 5, 1), v3(8, 5, 1), v3(5, 8, 1));
        par_tri      = tr(v3(1, 0, 0), v3(1, 1, 0), v3(1, 0, 1));
        junk         = tz(7);
        for (int i = 0; i < 16; i++) mem[i] = tz(2);

        rstn      = 1'b0;
        ray_valid = 1'b0;
        hit_ready = 1'b1;
        ray       = '0;
        num_tris  = '0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Basic hit against the golden triangle.
        mem[0] = basic_tri;
        send(ray_basic, 1, mk(1, 1'b1, 0, n_basic, 0, 4, 1));
        wait_result("basic", 50);
        @(negedge clk);

        // Late hit: three triangles behind the ray, fourth in front.
        mem[0] = tz(-1); mem[1] = tz(-2); mem[2] = tz(-3); mem[3] = tz(4); mem[4] = tz(5);
        send(ray_z, 4, mk(2, 1'b1, 3, n9, 0, 13, 4));
        wait_result("late", 80);
        @(negedge clk);

        // Full miss over five triangles.
        mem[0] = tz(-1); mem[1] = lat_tri; mem[2] = tz(-2); mem[3] = lat_tri; mem[4] = tz(-5);
        mem[5] = tz(2);
        send(ray_z, 5, mk(3, 1'b0, 0, '0, 0, 16, 5));
        wait_result("miss", 80);
        @(negedge clk);

        // Empty list.
        mem[0] = tz(2);
        send(ray_z, 0, mk(4, 1'b0, 0, '0, 0, 1, 0));
        wait_result("empty", 20);
        @(negedge clk);

        // Parallel triangles count as invalid, then a hit.
        mem[0] = par_tri; mem[1] = par_tri; mem[2] = tz(3);
        send(ray_z, 3, mk(5, 1'b1, 2, n9, 2, 10, 3));
        wait_result("invalid", 60);
        @(negedge clk);

        // Backpressure with a competing request held high.
        mem[0] = tz(2);
        hit_ready = 1'b0;
        send(ray_z, 1, mk(6, 1'b1, 0, n9, 0, 4, 1));
        wait_result("bp", 50);
        ray_b[0]  = v3(0, 0, -1);
        ray       = ray_b;
        num_tris  = (IW+1)'(1);
        ray_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_hit_valid", 128'(hit_valid), 128'(1));
            check("bp_ray_ready", 128'(ray_ready), 128'(0));
            check("bp_mem_rd", 128'(mem_rd), 128'(0));
            check("bp_hit", 128'(hit), 128'(1));
            check("bp_hit_idx", 128'(hit_idx), 128'(0));
            check("bp_normal", 128'(normal), 128'(n9));
            @(negedge clk);
        end
        hit_ready = 1'b1;
        @(negedge clk);
        check("hs_hit_valid", 128'(hit_valid), 128'(0));
        check("hs_ray_ready", 128'(ray_ready), 128'(1));
        check("hs_no_accept", 128'(mem_rd), 128'(0));
        sb.push_back(mk(7, 1'b1, 0, n9, 0, 4, 1));
        rd_base  = rd_total;
        acc_edge = cyc + 1;
        @(negedge clk);
        check("post_hs_accept", 128'(mem_rd), 128'(1));
        check("post_hs_ready", 128'(ray_ready), 128'(0));
        ray_valid = 1'b0;
        wait_result("post_hs", 50);
        @(negedge clk);

        // Reset in the WAIT cycle of index 2, then a fresh ray.
        mem[0] = tz(-1); mem[1] = tz(-2); mem[2] = tz(-3); mem[3] = tz(4);
        send(ray_z, 4, mk(8, 1'b1, 3, n9, 0, 13, 4));
        repeat (7) @(negedge clk);
        check("wait_idx2_addr", 128'(mem_addr), 128'(2));
        check("wait_idx2_rd", 128'(mem_rd), 128'(0));
        rstn = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_reset");
        sb.delete();
        rstn = 1'b1;
        @(negedge clk);
        mem[0] = basic_tri;
        send(ray_basic, 1, mk(9, 1'b1, 0, n_basic, 0, 4, 1));
        wait_result("after_reset", 50);
        @(negedge clk);
        @(negedge clk);

        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
